// File: rtl/mio_bus_arbiter_if.sv
// Bundle of every signal between the memory-port arbiter and its surroundings:
// the CPU requester, the secondary bus master, the shared memory port and the
// debug outputs. The slave modport is the arbiter's view of the bundle. The
// master modport is the view of the logic around it (requesters, memory,
// debug probe).
interface mio_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  // CPU requester (CPU_MIO / MemWrite)
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ready;

  // Secondary master (DMA / display fetch)
  logic              dev_req;
  logic              dev_we;
  logic [ADDR_W-1:0] dev_addr;
  logic [DATA_W-1:0] dev_wdata;
  logic [DATA_W-1:0] dev_rdata;
  logic              dev_ready;

  // Shared memory port
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Debug visibility
  logic [1:0]        grant_out;
  logic [1:0]        state_out;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ready,
    input  dev_req, dev_we, dev_addr, dev_wdata,
    output dev_rdata, dev_ready,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output grant_out, state_out
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ready,
    output dev_req, dev_we, dev_addr, dev_wdata,
    input  dev_rdata, dev_ready,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  grant_out, state_out
  );

endinterface

// File: rtl/mio_bus_arbiter.sv
// Round-robin arbiter that shares the single unified memory port between the
// multi-cycle CPU controller and one secondary bus master. A granted request
// is latched and held on the memory port for MEM_LAT cycles. The requester
// then gets a one-cycle ready pulse.
// Each transaction walks IDLE -> ACCESS (MEM_LAT cycles) -> DONE (ready) ->
// IDLE. Requests are only looked at in IDLE.
// All outputs come straight from flops. Their next values are computed from
// the next state, so the outputs line up with the state register.
module mio_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  mio_bus_arbiter_if.slave bus
);

  localparam int              CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_CPU  = 2'b01,
    GNT_DEV  = 2'b10
  } grant_e;

  state_e            state_q,     state_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  grant_e            grant_q,     grant_d;
  grant_e            lastGrant_q, lastGrant_d;

  logic              reqWe_q,     reqWe_d;
  logic [ADDR_W-1:0] reqAddr_q,   reqAddr_d;
  logic [DATA_W-1:0] reqWdata_q,  reqWdata_d;
  logic [DATA_W-1:0] rdata_q,     rdata_d;

  logic              memEn_q,     memEn_d;
  logic              memWe_q,     memWe_d;
  logic [ADDR_W-1:0] memAddr_q,   memAddr_d;
  logic [DATA_W-1:0] memWdata_q,  memWdata_d;
  logic              cpuReady_q,  cpuReady_d;
  logic              devReady_q,  devReady_d;

  logic              pickCpu;

  // The CPU wins when it is the only requester, or when both request and the
  // device was served last.
  assign pickCpu = bus.cpu_req && (!bus.dev_req || (lastGrant_q == GNT_DEV));

  // State and datapath registers. Reset drops any in-flight transaction and
  // leaves the device marked as last served, so the CPU wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      grant_q     <= GNT_NONE;
      lastGrant_q <= GNT_DEV;
      reqWe_q     <= 1'b0;
      reqAddr_q   <= '0;
      reqWdata_q  <= '0;
      rdata_q     <= '0;
      memEn_q     <= 1'b0;
      memWe_q     <= 1'b0;
      memAddr_q   <= '0;
      memWdata_q  <= '0;
      cpuReady_q  <= 1'b0;
      devReady_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      lastGrant_q <= lastGrant_d;
      reqWe_q     <= reqWe_d;
      reqAddr_q   <= reqAddr_d;
      reqWdata_q  <= reqWdata_d;
      rdata_q     <= rdata_d;
      memEn_q     <= memEn_d;
      memWe_q     <= memWe_d;
      memAddr_q   <= memAddr_d;
      memWdata_q  <= memWdata_d;
      cpuReady_q  <= cpuReady_d;
      devReady_q  <= devReady_d;
    end
  end

  // Next state. IDLE arbitrates and latches the winner's command. ACCESS
  // counts down the memory latency and captures read data on its last cycle.
  // DONE always returns to IDLE, so a held request is arbitrated again.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    lastGrant_d = lastGrant_q;
    reqWe_d     = reqWe_q;
    reqAddr_d   = reqAddr_q;
    reqWdata_d  = reqWdata_q;
    rdata_d     = rdata_q;

    case (state_q)
      ST_IDLE: begin
        grant_d = GNT_NONE;
        if (bus.cpu_req || bus.dev_req) begin
          state_d = ST_ACCESS;
          cnt_d   = CNT_LOAD;
          if (pickCpu) begin
            grant_d     = GNT_CPU;
            lastGrant_d = GNT_CPU;
            reqWe_d     = bus.cpu_we;
            reqAddr_d   = bus.cpu_addr;
            reqWdata_d  = bus.cpu_wdata;
          end else begin
            grant_d     = GNT_DEV;
            lastGrant_d = GNT_DEV;
            reqWe_d     = bus.dev_we;
            reqAddr_d   = bus.dev_addr;
            reqWdata_d  = bus.dev_wdata;
          end
        end
      end

      ST_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          if (!reqWe_q) begin
            rdata_d = bus.mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        grant_d = GNT_NONE;
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = GNT_NONE;
      end
    endcase
  end

  // Output decode from the next state. The memory port is live only in
  // ACCESS and reads zero otherwise. Ready goes only to the granted master.
  always_comb begin
    memEn_d    = (state_d == ST_ACCESS);
    memWe_d    = memEn_d && reqWe_d;
    memAddr_d  = memEn_d ? reqAddr_d  : '0;
    memWdata_d = memEn_d ? reqWdata_d : '0;
    cpuReady_d = (state_d == ST_DONE) && (grant_d == GNT_CPU);
    devReady_d = (state_d == ST_DONE) && (grant_d == GNT_DEV);
  end

  assign bus.cpu_rdata = rdata_q;
  assign bus.dev_rdata = rdata_q;
  assign bus.cpu_ready = cpuReady_q;
  assign bus.dev_ready = devReady_q;
  assign bus.mem_en    = memEn_q;
  assign bus.mem_we    = memWe_q;
  assign bus.mem_addr  = memAddr_q;
  assign bus.mem_wdata = memWdata_q;
  assign bus.grant_out = grant_q;
  assign bus.state_out = state_q;

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Testbench for mio_bus_arbiter. A behavioural memory sits on the memory port.
// The reference model keeps, at transaction level:
//   - the memory image,
//   - the ordered list of outstanding transactions for each master,
//   - the last value read.
// Each master uses its own address region, so that master's program order
// alone fixes its expected read data.
// A monitor pops one expected transaction per ready pulse and compares it.
module tb_mio_bus_arbiter;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int MEM_LAT  = 2;
  localparam int WAIT_MAX = 2 * MEM_LAT + 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mio_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mio_bus_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .MEM_LAT(MEM_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
  } txn_t;

  txn_t              cpuQ[$];
  txn_t              devQ[$];
  logic [DATA_W-1:0] envMem [256];
  logic [DATA_W-1:0] refMem [256];
  logic [DATA_W-1:0] lastRead;
  int                nChecks = 0;
  int                nErrors = 0;
  int                enCount = 0;

  function automatic logic [DATA_W-1:0] memInit(input int i);
    if (i == 'h10) return 32'hDEADBEEF;
    return 32'h5A000000 ^ (i * 32'h00010203);
  endfunction

  // Behavioural memory: combinational read of the addressed word, write on
  // every enabled write cycle.
  assign bus.mem_rdata = bus.mem_en ? envMem[bus.mem_addr[7:0]] : 32'hBAD0BAD0;

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) envMem[bus.mem_addr[7:0]] = bus.mem_wdata;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Raise a request and record its expected outcome in the reference model.
  task automatic issue(input bit isDev, input bit we, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] wdata);
    txn_t t;
    t.we    = we;
    t.addr  = addr;
    t.wdata = wdata;
    t.rdata = refMem[addr[7:0]];
    if (we) refMem[addr[7:0]] = wdata;
    if (isDev) begin
      devQ.push_back(t);
      bus.dev_req = 1'b1; bus.dev_we = we; bus.dev_addr = addr; bus.dev_wdata = wdata;
    end else begin
      cpuQ.push_back(t);
      bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    end
  endtask

  task automatic dropReq(input bit isDev);
    if (isDev) bus.dev_req = 1'b0;
    else       bus.cpu_req = 1'b0;
  endtask

  // Wait, with a bound, for the ready pulse of one master.
  task automatic waitReady(input bit isDev, input string name);
    bit got = 1'b0;
    for (int c = 0; c < WAIT_MAX && !got; c++) begin
      tick();
      got = isDev ? bus.dev_ready : bus.cpu_ready;
    end
    checkOutput(name, got, 1);
  endtask

  task automatic applyStimulus(input bit isDev, input bit we,
                               input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] wdata);
    issue(isDev, we, addr, wdata);
    waitReady(isDev, isDev ? "devReadyInBound" : "cpuReadyInBound");
    dropReq(isDev);
  endtask

  task automatic agentLoop(input bit isDev, input int n);
    logic [ADDR_W-1:0] base;
    base = isDev ? 32'h80 : 32'h00;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(1, 3)) tick();
      applyStimulus(isDev, 1'($urandom_range(0, 1)),
                    base + 32'(4 * $urandom_range(0, 15)), $urandom);
    end
  endtask

  // Monitor: per-cycle bus rules, memory-port contents against the in-flight
  // transaction, and the completed transaction on every ready pulse.
  always @(negedge clk) begin
    txn_t t;
    bit   have;
    bit   isDev;
    checkOutput("readyExclusive", 64'(bus.cpu_ready & bus.dev_ready), 0);
    if (bus.state_out == 2'b00) checkOutput("idleGrantZero", bus.grant_out, 0);
    if (bus.mem_en) begin
      enCount++;
      have = 1'b0;
      if (bus.grant_out == 2'b01 && cpuQ.size() != 0) begin t = cpuQ[0]; have = 1'b1; end
      if (bus.grant_out == 2'b10 && devQ.size() != 0) begin t = devQ[0]; have = 1'b1; end
      checkOutput("memGrantMatchesPending", have, 1);
      if (have) begin
        checkOutput("memAddr", bus.mem_addr, t.addr);
        checkOutput("memWe", bus.mem_we, t.we);
        if (t.we) checkOutput("memWdata", bus.mem_wdata, t.wdata);
      end
    end else if (bus.cpu_ready || bus.dev_ready) begin
      isDev = bus.dev_ready;
      checkOutput("accessCycles", enCount, MEM_LAT);
      checkOutput("rdataShared", bus.cpu_rdata, bus.dev_rdata);
      have = isDev ? (devQ.size() != 0) : (cpuQ.size() != 0);
      checkOutput(isDev ? "devReadyExpected" : "cpuReadyExpected", have, 1);
      if (have) begin
        t = isDev ? devQ.pop_front() : cpuQ.pop_front();
        if (!t.we) begin
          checkOutput(isDev ? "devReadData" : "cpuReadData",
                      isDev ? bus.dev_rdata : bus.cpu_rdata, t.rdata);
          lastRead = t.rdata;
        end else begin
          checkOutput("writeKeepsRdata", bus.cpu_rdata, lastRead);
        end
      end
      enCount = 0;
    end else begin
      enCount = 0;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int order [4];
    int when  [4];
    int nReady;

    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dev_req = 0; bus.dev_we = 0; bus.dev_addr = '0; bus.dev_wdata = '0;
    rst = 1'b1;
    for (int i = 0; i < 256; i++) begin
      envMem[i] = memInit(i);
      refMem[i] = memInit(i);
    end
    lastRead = '0;

    $display("[TB] reset state");
    tick(); tick();
    checkOutput("rstState", bus.state_out, 0);
    checkOutput("rstGrant", bus.grant_out, 0);
    checkOutput("rstMemEn", bus.mem_en, 0);
    checkOutput("rstMemWe", bus.mem_we, 0);
    checkOutput("rstCpuReady", bus.cpu_ready, 0);
    checkOutput("rstDevReady", bus.dev_ready, 0);
    rst = 1'b0;
    tick();
    checkOutput("idleNoReq", bus.state_out, 0);

    $display("[TB] CPU read");
    issue(0, 0, 32'h10, 32'h0);
    tick();
    checkOutput("aState1", bus.state_out, 1);
    checkOutput("aMemEn1", bus.mem_en, 1);
    checkOutput("aMemAddr1", bus.mem_addr, 32'h10);
    checkOutput("aGrant", bus.grant_out, 1);
    bus.cpu_addr = 32'h99;
    tick();
    checkOutput("aMemEn2", bus.mem_en, 1);
    checkOutput("aMemAddr2", bus.mem_addr, 32'h10);
    tick();
    checkOutput("aCpuReady", bus.cpu_ready, 1);
    checkOutput("aCpuRdata", bus.cpu_rdata, 32'hDEADBEEF);
    checkOutput("aDevReady", bus.dev_ready, 0);
    checkOutput("aMemEnDone", bus.mem_en, 0);
    checkOutput("aStateDone", bus.state_out, 2);
    dropReq(0);
    tick();
    checkOutput("aIdle", bus.state_out, 0);
    checkOutput("aReadyGone", bus.cpu_ready, 0);

    $display("[TB] device write");
    issue(1, 1, 32'h40, 32'h1234);
    tick();
    checkOutput("bMemWe1", bus.mem_we, 1);
    checkOutput("bMemWdata1", bus.mem_wdata, 32'h1234);
    checkOutput("bMemAddr", bus.mem_addr, 32'h40);
    checkOutput("bGrant", bus.grant_out, 2);
    tick();
    checkOutput("bMemWe2", bus.mem_we, 1);
    checkOutput("bMemWdata2", bus.mem_wdata, 32'h1234);
    tick();
    checkOutput("bDevReady", bus.dev_ready, 1);
    checkOutput("bRdataKept", bus.dev_rdata, 32'hDEADBEEF);
    checkOutput("bCpuReady", bus.cpu_ready, 0);
    dropReq(1);
    tick();
    checkOutput("bIdle", bus.state_out, 0);

    $display("[TB] both requesting from reset");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cpuQ.delete(); devQ.delete(); lastRead = '0;
    issue(0, 0, 32'h10, 32'h0);
    issue(0, 0, 32'h10, 32'h0);
    issue(1, 0, 32'h84, 32'h0);
    issue(1, 0, 32'h84, 32'h0);
    nReady = 0;
    for (int c = 1; c <= 30 && nReady < 4; c++) begin
      tick();
      if (bus.cpu_ready) begin order[nReady] = 0; when[nReady] = c; nReady++; end
      if (bus.dev_ready) begin order[nReady] = 1; when[nReady] = c; nReady++; end
      if (nReady == 4) begin dropReq(0); dropReq(1); end
    end
    dropReq(0); dropReq(1);
    checkOutput("cReadyCount", nReady, 4);
    if (nReady == 4) begin
      checkOutput("cFirstLatency", when[0], MEM_LAT + 1);
      for (int i = 0; i < 4; i++) begin
        checkOutput("cGrantOrder", order[i], i % 2);
        if (i > 0) checkOutput("cReadySpacing", when[i] - when[i-1], MEM_LAT + 2);
      end
    end
    tick();

    $display("[TB] reset during access");
    issue(0, 0, 32'h20, 32'h0);
    tick(); tick();
    checkOutput("dAccess2", bus.state_out, 1);
    rst = 1'b1;
    bus.dev_req = 1'b1; bus.dev_we = 1'b0; bus.dev_addr = 32'h90;
    tick();
    rst = 1'b0;
    checkOutput("dState", bus.state_out, 0);
    checkOutput("dMemEn", bus.mem_en, 0);
    checkOutput("dNoCpuReady", bus.cpu_ready, 0);
    checkOutput("dGrantZero", bus.grant_out, 0);
    cpuQ.delete(); devQ.delete(); lastRead = '0;
    issue(0, 0, 32'h20, 32'h0);
    issue(1, 0, 32'h90, 32'h0);
    tick();
    checkOutput("dCpuFirst", bus.grant_out, 1);
    waitReady(0, "dCpuReady");
    dropReq(0);
    waitReady(1, "dDevReady");
    dropReq(1);
    tick();

    $display("[TB] request dropped during access");
    issue(0, 0, 32'h24, 32'h0);
    tick();
    dropReq(0);
    tick(); tick();
    checkOutput("eCpuReady", bus.cpu_ready, 1);
    tick();
    checkOutput("eIdle1", bus.state_out, 0);
    checkOutput("eGrant1", bus.grant_out, 0);
    tick();
    checkOutput("eIdle2", bus.state_out, 0);
    checkOutput("eMemEn2", bus.mem_en, 0);

    $display("[TB] back-to-back CPU");
    issue(0, 1, 32'h28, $urandom);
    tick(); tick(); tick();
    checkOutput("fFirstReady", bus.cpu_ready, 1);
    issue(0, 0, 32'h2C, 32'h0);
    tick();
    checkOutput("fIdleBetween", bus.state_out, 0);
    tick();
    checkOutput("fSecondAccess", bus.state_out, 1);
    checkOutput("fSecondAddr", bus.mem_addr, 32'h2C);
    checkOutput("fSecondGrant", bus.grant_out, 1);
    waitReady(0, "fSecondReady");
    dropReq(0);
    tick();

    $display("[TB] random traffic from both masters");
    fork
      agentLoop(0, 30);
      agentLoop(1, 30);
    join
    repeat (4) tick();
    checkOutput("cpuQueueDrained", cpuQ.size(), 0);
    checkOutput("devQueueDrained", devQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule

// File: doc/mio_bus_arbiter.md
# mio_bus_arbiter

Shares the single unified instruction/data memory port between the multi-cycle CPU control (CPU_MIO / MemWrite requester) and one secondary bus master (DMA or display fetch). It runs a round-robin grant, holds the granted request's address, write-enable and write data stable to memory for a fixed access latency, and returns a one-cycle ready pulse. The CPU's ready output drives the controller's MIO_ready input.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, memory access cycles per transaction (>=1)
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU memory request (CPU_MIO); held until cpu_ready
- cpu_we  in  1  1 = write (MemWrite), 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  read data, valid while cpu_ready=1
- cpu_ready  out  1  one-cycle completion pulse to CPU (MIO_ready)
- dev_req, dev_we, dev_addr, dev_wdata  in  1/1/ADDR_W/DATA_W  secondary master request, same rules as CPU
- dev_rdata  out  DATA_W  read data, valid while dev_ready=1
- dev_ready  out  1  one-cycle completion pulse to device
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid in last ACCESS cycle
- grant_out  out  2  01 = CPU granted, 10 = device granted, 00 = none
- state_out  out  2  FSM state (debug)

## Operation
- FSM states: IDLE=00, ACCESS=01, DONE=10. Code 11 is illegal and returns to IDLE.
- IDLE:
  - No request: stay in IDLE.
  - Any request: grant, latch that requester's we/addr/wdata into internal registers, load counter = MEM_LAT-1, go to ACCESS.
- Arbitration: round-robin on last_grant.
  - If both requests are high, grant the requester that was not served last.
  - If only one is high, grant it.
  - last_grant updates at grant time.
  - After reset last_grant = device, so the CPU wins the first tie.
- ACCESS:
  - mem_en=1; mem_we/mem_addr/mem_wdata driven from the latched registers and stable for all MEM_LAT cycles.
  - Counter decrements each cycle.
  - When counter = 0: capture mem_rdata into rdata_q (reads only; writes leave rdata_q unchanged), go to DONE.
- DONE:
  - mem_en=0; the granted requester's ready=1 for exactly this cycle.
  - cpu_rdata and dev_rdata both show rdata_q.
  - Next state is always IDLE. No grant is made in DONE, so a request still held or newly raised is re-arbitrated in IDLE.
- Requests are sampled only in IDLE. A request dropped during ACCESS does not abort: the memory access completes and ready still pulses. Address or data changes after grant are ignored.
- grant_out is nonzero in ACCESS and DONE and shows the granted requester; it is 00 in IDLE.
- Reset (any state, including mid-ACCESS):
  - Next state IDLE; mem_en=0, mem_we=0, cpu_ready=0, dev_ready=0, grant_out=00.
  - rdata_q=0, counter=0, last_grant=device.
  - An interrupted transaction is lost and no ready pulse is issued for it.

## Timing
- Request high in IDLE at edge k: ACCESS in cycles k+1..k+MEM_LAT, DONE (ready) in cycle k+MEM_LAT+1, IDLE in k+MEM_LAT+2.
- Latency from sampled request to ready: MEM_LAT+1 cycles. Bus occupancy per transaction: MEM_LAT+2 cycles.
- Worst-case wait for a continuously requesting master: one foreign transaction, i.e. MEM_LAT+2 cycles, before its own grant. Neither master can starve.
- Ready outputs are registered and mutually exclusive; they never assert in the same cycle.
- Memory outputs are registered; mem_* values are 0 in IDLE and DONE.

## Test plan
- Reset, then cpu_req=1, cpu_we=0, cpu_addr=0x10, mem_rdata=0xDEADBEEF, MEM_LAT=2:
  - mem_en=1 with mem_addr=0x10 for exactly 2 cycles.
  - cpu_ready=1 with cpu_rdata=0xDEADBEEF 3 cycles after the request was sampled.
  - dev_ready stays 0.
- Device write dev_we=1, dev_addr=0x40, dev_wdata=0x1234:
  - mem_we=1, mem_wdata=0x1234 for 2 cycles.
  - dev_ready pulses once.
  - rdata_q keeps its previous value.
- cpu_req and dev_req held high together from reset:
  - Grants alternate CPU, device, CPU, device.
  - Each ready arrives 4 cycles after the other.
  - No cycle has both readies high.
- Reset asserted in the 2nd ACCESS cycle of a CPU read:
  - Next cycle state_out=00, mem_en=0, no cpu_ready.
  - With both requests high, the CPU is granted first.
- cpu_req dropped during ACCESS:
  - cpu_ready still pulses once in DONE.
  - The arbiter returns to IDLE and stays there with grant_out=00.
- Back-to-back CPU requests (cpu_req held high across DONE):
  - A second grant occurs in the IDLE cycle after DONE.
  - The mem_addr update is visible in the following ACCESS cycle.
